// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: turns each rx_ready rising edge into
// one FIFO write, counts framing errors and serves bytes through a registered read port.
module uart_rx_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter bit          DROP_ERR = 1'b1
) (
  input  logic                     clk50m,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_ready,
  input  logic                     rx_error,
  input  logic                     rd_en,
  input  logic                     clr_stat,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             rdy_q;
  logic             armed_q;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q;
  logic             overflow_q, overflow_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic frame, err_frame, wr, rd, wr_ok, wr_lost;

  // armed_q stays low until rx_ready has been seen low after reset, so a level
  // already high at reset release is never mistaken for a new frame.
  assign frame     = rx_ready & ~rdy_q & armed_q;
  assign err_frame = frame & rx_error;
  assign wr        = frame & ~(DROP_ERR & rx_error);
  assign rd        = rd_en & ~empty;
  assign wr_ok     = wr & (~full | rd);
  assign wr_lost   = wr & full & ~rd;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign overflow = overflow_q;
  assign err_cnt  = err_cnt_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    overflow_d = clr_stat ? 1'b0 : overflow_q;
    err_cnt_d  = clr_stat ? 8'd0 : err_cnt_q;

    if (wr_ok) wptr_d = wptr_q + AW'(1);
    if (rd) begin
      rptr_d    = rptr_q + AW'(1);
      rd_data_d = mem_q[rptr_q];
    end

    case ({wr_ok, rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // New events are applied after the clear so they win in the same cycle.
    if (wr_lost) overflow_d = 1'b1;
    if (err_frame && err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'd1;
  end

  always_ff @(posedge clk50m) begin
    if (wr_ok) mem_q[wptr_q] <= rx_data;
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rdy_q      <= 1'b0;
      armed_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rdy_q      <= rx_ready;
      armed_q    <= armed_q | ~rx_ready;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives two instances (errors dropped / errors stored)
// with the same stimulus and compares both against a queue-based reference.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk50m;
  logic       rstN;
  logic [7:0] rxData;
  logic       rxReady;
  logic       rxError;
  logic       rdEn;
  logic       clrStat;

  logic [7:0] rdDataD, rdDataK;
  logic       rdValidD, rdValidK;
  logic       emptyD, emptyK;
  logic       fullD, fullK;
  logic [4:0] countD, countK;
  logic       overflowD, overflowK;
  logic [7:0] errCntD, errCntK;

  int checks   = 0;
  int failures = 0;
  string stepName = "init";

  // Reference state: index 0 models the error-dropping instance, 1 the storing one.
  logic [7:0] mqD[$];
  logic [7:0] mqK[$];
  int         errM[2];
  bit         ovfM[2];
  logic [7:0] rdDataM[2];
  bit         rdValidM[2];
  bit         prevReady;

  uart_rx_fifo #(.WIDTH(8), .DEPTH(DEPTH), .DROP_ERR(1'b1)) dutD (
    .clk50m(clk50m), .rst_n(rstN), .rx_data(rxData), .rx_ready(rxReady),
    .rx_error(rxError), .rd_en(rdEn), .clr_stat(clrStat),
    .rd_data(rdDataD), .rd_valid(rdValidD), .empty(emptyD), .full(fullD),
    .count(countD), .overflow(overflowD), .err_cnt(errCntD)
  );

  uart_rx_fifo #(.WIDTH(8), .DEPTH(DEPTH), .DROP_ERR(1'b0)) dutK (
    .clk50m(clk50m), .rst_n(rstN), .rx_data(rxData), .rx_ready(rxReady),
    .rx_error(rxError), .rd_en(rdEn), .clr_stat(clrStat),
    .rd_data(rdDataK), .rd_valid(rdValidK), .empty(emptyK), .full(fullK),
    .count(countK), .overflow(overflowK), .err_cnt(errCntK)
  );

  initial clk50m = 1'b0;
  always #10 clk50m = ~clk50m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("[TB] FAIL %s/%s observed=%0h expected=%0h", stepName, tag, obs, expv);
      $error("[TB] %s/%s observed=%0h expected=%0h", stepName, tag, obs, expv);
    end
  endtask

  task automatic checkAll();
    chk("countD",    32'(countD),    32'(mqD.size()));
    chk("emptyD",    32'(emptyD),    32'(mqD.size() == 0));
    chk("fullD",     32'(fullD),     32'(mqD.size() == DEPTH));
    chk("overflowD", 32'(overflowD), 32'(ovfM[0]));
    chk("errCntD",   32'(errCntD),   32'(errM[0]));
    chk("rdValidD",  32'(rdValidD),  32'(rdValidM[0]));
    chk("rdDataD",   32'(rdDataD),   32'(rdDataM[0]));
    chk("countK",    32'(countK),    32'(mqK.size()));
    chk("emptyK",    32'(emptyK),    32'(mqK.size() == 0));
    chk("fullK",     32'(fullK),     32'(mqK.size() == DEPTH));
    chk("overflowK", 32'(overflowK), 32'(ovfM[1]));
    chk("errCntK",   32'(errCntK),   32'(errM[1]));
    chk("rdValidK",  32'(rdValidK),  32'(rdValidM[1]));
    chk("rdDataK",   32'(rdDataK),   32'(rdDataM[1]));
  endtask

  // One clock edge of the reference: a rising rx_ready is one frame; reads pop
  // the oldest byte before a write is considered, so a full FIFO can take both.
  task automatic modelEdge();
    bit frm;
    frm = rxReady && !prevReady;
    for (int k = 0; k < 2; k++) begin
      bit keep;
      bit rdM;
      int occ;
      keep = frm && !(k == 0 && rxError);
      occ  = (k == 0) ? mqD.size() : mqK.size();
      rdM  = rdEn && (occ > 0);
      rdValidM[k] = rdM;
      if (clrStat) begin
        ovfM[k] = 1'b0;
        errM[k] = 0;
      end
      if (frm && rxError && errM[k] < 255) errM[k]++;
      if (rdM) rdDataM[k] = (k == 0) ? mqD.pop_front() : mqK.pop_front();
      if (keep) begin
        if (occ < DEPTH || rdM) begin
          if (k == 0) mqD.push_back(rxData);
          else        mqK.push_back(rxData);
        end else begin
          ovfM[k] = 1'b1;
        end
      end
    end
    prevReady = rxReady;
  endtask

  task automatic applyStimulus();
    @(posedge clk50m);
    if (rstN) modelEdge();
    #1;
    checkAll();
  endtask

  task automatic sendFrame(input logic [7:0] d, input bit err, input bit rd);
    rxData  = d;
    rxError = err;
    rxReady = 1'b1;
    rdEn    = rd;
    applyStimulus();
    rxReady = 1'b0;
    rxError = 1'b0;
    rdEn    = 1'b0;
    applyStimulus();
  endtask

  task automatic readN(input int n);
    rdEn = 1'b1;
    repeat (n) applyStimulus();
    rdEn = 1'b0;
    applyStimulus();
  endtask

  // Reset is asserted between edges; the level of rx_ready at release is not a frame.
  task automatic doReset();
    rstN = 1'b0;
    mqD.delete();
    mqK.delete();
    for (int k = 0; k < 2; k++) begin
      errM[k]     = 0;
      ovfM[k]     = 1'b0;
      rdDataM[k]  = 8'h00;
      rdValidM[k] = 1'b0;
    end
    prevReady = 1'b1;
    #2;
    checkAll();
    repeat (2) applyStimulus();
    rstN = 1'b1;
  endtask

  initial begin
    rstN = 1'b1; rxData = 8'h00; rxReady = 1'b0; rxError = 1'b0;
    rdEn = 1'b0; clrStat = 1'b0;
    #3;
    stepName = "reset";
    doReset();
    applyStimulus();

    stepName = "single";
    rxData = 8'hA5;
    rxReady = 1'b1;
    repeat (5) applyStimulus();
    rxReady = 1'b0;
    applyStimulus();
    readN(1);
    applyStimulus();

    stepName = "fill";
    for (int i = 0; i < 16; i++) sendFrame(8'(i), 1'b0, 1'b0);
    sendFrame(8'hFF, 1'b0, 1'b0);
    readN(16);
    stepName = "wrap";
    for (int i = 16; i < 20; i++) sendFrame(8'(i), 1'b0, 1'b0);
    readN(4);

    stepName = "fullSim";
    clrStat = 1'b1; applyStimulus(); clrStat = 1'b0;
    for (int i = 0; i < 16; i++) sendFrame(8'($urandom), 1'b0, 1'b0);
    sendFrame(8'h55, 1'b0, 1'b1);
    readN(17);

    stepName = "emptySim";
    sendFrame(8'($urandom), 1'b0, 1'b1);
    readN(1);

    stepName = "errors";
    sendFrame(8'h11, 1'b0, 1'b0);
    sendFrame(8'h22, 1'b1, 1'b0);
    sendFrame(8'h33, 1'b0, 1'b0);
    readN(4);
    for (int i = 0; i < 300; i++) sendFrame(8'($urandom), 1'b1, 1'b0);
    clrStat = 1'b1; applyStimulus(); clrStat = 1'b0;
    applyStimulus();
    stepName = "clrRace";
    clrStat = 1'b1;
    sendFrame(8'hE7, 1'b1, 1'b0);
    clrStat = 1'b0;
    readN(17);

    stepName = "emptyRead";
    rdEn = 1'b1;
    repeat (10) applyStimulus();
    rdEn = 1'b0;

    stepName = "midReset";
    for (int i = 0; i < 5; i++) sendFrame(8'($urandom), 1'b0, 1'b0);
    rxData = 8'h9C;
    rxReady = 1'b1;
    doReset();
    repeat (3) applyStimulus();
    rxReady = 1'b0;
    applyStimulus();
    rxReady = 1'b1;
    applyStimulus();
    rxReady = 1'b0;
    readN(2);

    stepName = "random";
    for (int i = 0; i < 800; i++) begin
      rxReady = 1'($urandom_range(0, 1));
      rxError = ($urandom_range(0, 3) == 0);
      rxData  = 8'($urandom);
      rdEn    = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clrStat = ($urandom_range(0, 50) == 0);
      applyStimulus();
    end
    rxReady = 1'b0; rxError = 1'b0; rdEn = 1'b0; clrStat = 1'b0;
    readN(17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer that sits directly downstream of the UART receiver. It detects each completed frame from the receiver's `rx_ready` flag, captures the byte into a circular FIFO, and counts framing errors. It hands bytes to the consuming logic through a registered read handshake.

## Interface
- `WIDTH`, 8: data word width; must match the receiver.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `DROP_ERR`, 1: 1 = discard frames flagged `rx_error`; 0 = store them.

Ports:
- `clk50m` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in WIDTH: received byte; valid while `rx_ready`=1.
- `rx_ready` in 1: receiver frame-complete flag; level, held ≥1 cycle.
- `rx_error` in 1: receiver stop-bit error flag; qualified by `rx_ready`.
- `rd_en` in 1: read request from the consumer.
- `clr_stat` in 1: synchronous pulse; clears `overflow` and `err_cnt`.
- `rd_data` out WIDTH: read word; registered.
- `rd_valid` out 1: one-cycle strobe; `rd_data` updated this cycle.
- `empty` out 1: FIFO holds 0 entries.
- `full` out 1: FIFO holds DEPTH entries.
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a byte was lost because the FIFO was full.
- `err_cnt` out 8: framing-error counter; saturates at 255.

## Operation
- **Frame detect.** Register `rx_ready` into `rdy_q` (reset 0).
  - `frame = rx_ready & ~rdy_q`, a one-cycle event.
  - A `rx_ready` that is already high when reset releases is not a frame. Capture happens only after it falls and rises again.
- **Error handling.** `rx_error` is sampled only in the `frame` cycle.
  - On `frame & rx_error`: `err_cnt` increments, saturating at 255.
  - If `DROP_ERR`=1, the byte is not written. If `DROP_ERR`=0, it is written like a good frame.
- **Write.** `wr = frame & ~(DROP_ERR & rx_error)`.
  - If `wr` and the FIFO is not full, or is full with an accepted read in the same cycle: store `rx_data` at `wptr`; `wptr` increments and wraps modulo DEPTH.
  - If `wr` and full with no read: byte dropped, `overflow` set to 1, pointers unchanged.
- **Read.** `rd = rd_en & ~empty`.
  - On `rd`: `rd_data` ← `mem[rptr]`; `rptr` increments and wraps; `rd_valid`=1 for exactly that one cycle.
  - `rd_en` while empty is ignored: `rd_data` holds, `rd_valid`=0.
  - There is no write-to-read bypass. `rd_en` on the same edge the first byte is written returns nothing.
- **Occupancy.** `count` changes by +1 for a write only, −1 for a read only, and 0 when both occur.
  - `empty = (count==0)`, `full = (count==DEPTH)`, both derived from registered `count`.
  - Pointers are $clog2(DEPTH) bits. `count` carries the extra bit that distinguishes full from empty.
- **Clear.** `clr_stat` zeroes `overflow` and `err_cnt`. If a new error or overflow occurs in the same cycle, the set or increment wins: `overflow`=1 and `err_cnt`=1.
- **Reset (async).**
  - Pointers, `count`, `rdy_q`, `rd_data`, `rd_valid`, `overflow`, `err_cnt` → 0.
  - Therefore `empty`=1 and `full`=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored bytes. A frame in progress at the receiver is captured only if its `rx_ready` rises after reset release.

## Timing
- **Write latency.** If `rx_ready` is first seen high at edge n, the byte is written at edge n. After edge n: `count`+1, `empty`=0.
- **Read latency.** If `rd_en`=1 and `empty`=0 at edge k, then `rd_data` and `rd_valid` are valid after edge k. `count`−1 after the same edge.
- **Back-to-back.** Reads are allowed on every cycle; with `rd_en` held, DEPTH bytes drain in DEPTH cycles.
- **Write rate.** At most one write per `rx_ready` rising edge, so a level held for many cycles writes once.
- **Full boundary.** With FIFO full and `frame` and `rd` on the same edge: both happen, `count` stays DEPTH, `overflow` stays 0.
- **Empty boundary.** With FIFO empty and `frame` and `rd_en` on the same edge: write only. `count`=1 and `rd_valid`=0.
- `full`, `empty`, `count`, `overflow` and `err_cnt` are all registered or derived from registers only; none depends combinationally on inputs.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-stream → all outputs 0 except `empty`=1. `rx_ready` held high across reset release → no write until it toggles.
- **Single byte.** One frame with `rx_data`=0xA5, `rx_ready` high for 5 cycles → `count`=1 (one write only). `rd_en` pulse → `rd_data`=0xA5 and `rd_valid` high exactly 1 cycle, then `empty`=1.
- **Fill and wrap.** Write 16 frames 0x00..0x0F → `full`=1, `count`=16. 17th frame 0xFF → `overflow`=1, `count`=16. Read all → 0x00..0x0F in order. Write 0x10..0x13 → after wrap they read back correctly.
- **Simultaneous events.**
  - Full FIFO with `frame` 0x55 and `rd_en` on one edge → `count`=16, `overflow`=0; 0x55 is read last.
  - Empty FIFO with `frame` and `rd_en` together → `count`=1, `rd_valid`=0.
- **Errors.** `DROP_ERR`=1 with 3 frames, middle one `rx_error`=1 → `count`=2, `err_cnt`=1. 300 error frames → `err_cnt`=255. `clr_stat` → 0. Repeat with `DROP_ERR`=0 → every error byte is stored.
- **Empty read.** `rd_en` held high on an empty FIFO for 10 cycles → `rd_valid`=0, `rd_data` unchanged, `count`=0.
